// File: rtl/freq_gate_ctrl.sv
// Gate window generator and result capture: period high GATE_CYCLES after start, result valid GATE+SETTLE+1 edges after start.
// Output is a single holding register; a capture while valid&!ready overwrites and raises sticky overrun.
module freq_gate_ctrl #(
    parameter int CNT_W         = 40,
    parameter int TIMER_W       = 32,
    parameter int GATE_CYCLES   = 50_000_000,
    parameter int SETTLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    output logic             period,
    input  logic [CNT_W-1:0] counter_in,
    output logic [CNT_W-1:0] result_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GATE    = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        GAP     = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] GATE_LAST   = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST    = TIMER_W'(GAP_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = GATE;
            GATE:    if (timer == GATE_LAST) state_nxt = SETTLE;
            SETTLE:  if (timer == SETTLE_LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = GAP;
            GAP:     if (timer == GAP_LAST) state_nxt = cont ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Timer restarts on every state change and parks at zero in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            period <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= (state_nxt != state || state == IDLE) ? '0 : timer + TIMER_W'(1);
            period <= (state_nxt == GATE);
        end
    end

    // counter_in is only sampled in CAPTURE, after the settle window has let the bus go static.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_data  <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (state == CAPTURE) begin
                result_data  <= counter_in;
                result_valid <= 1'b1;
                if (result_valid && !result_ready) overrun <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            if (state == IDLE && start) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: directed scenarios with literal expectations plus random traffic vs a timeline model.
module tb_freq_gate_ctrl;

    localparam int G   = 10;
    localparam int S   = 2;
    localparam int GP  = 3;
    localparam int CW  = 40;
    localparam int CAP = G + S + 1;
    localparam int L   = G + S + 1 + GP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          period;
    logic [CW-1:0] counter_in = '0;
    logic [CW-1:0] result_data;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic          overrun;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    freq_gate_ctrl #(
        .CNT_W(CW), .TIMER_W(32), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .GAP_CYCLES(GP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .period(period),
        .counter_in(counter_in), .result_data(result_data), .result_valid(result_valid),
        .result_ready(result_ready), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a measurement is a timeline anchored at its start edge t0; everything follows from edge - t0.
    int            cyc = 0;
    int            t0 = 0;
    bit            act = 1'b0;
    logic          m_period = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;
    logic [CW-1:0] m_data = '0;

    always begin
        int d;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            act = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
        end else begin
            d = cyc - t0;
            if (act && d == CAP) begin
                if (m_valid && !result_ready) m_ovr = 1'b1;
                m_data  = counter_in;
                m_valid = 1'b1;
            end else if (m_valid && result_ready) begin
                m_valid = 1'b0;
            end
            if (act) begin
                if (d == L) begin
                    if (cont) t0 = cyc;
                    else act = 1'b0;
                end
            end else if (start) begin
                act = 1'b1; t0 = cyc; m_ovr = 1'b0;
            end
        end
        m_period = act && ((cyc - t0) < G);
        m_busy   = act;
        #1;
        chk("period", 64'(period), 64'(m_period));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("valid", 64'(result_valid), 64'(m_valid));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("data", 64'(result_data), 64'(m_data));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        int rise[3];
        int nr, hi;
        logic prev;
        logic [63:0] r;

        // Reset
        tick(3);
        chk("rst_period", 64'(period), 0);
        chk("rst_valid", 64'(result_valid), 0);
        chk("rst_data", 64'(result_data), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_busy", 64'(busy), 0);
        rst_n = 1'b1;
        tick(2);

        // Single shot: observations are taken just after edge k
        counter_in = 40'd1234;
        pulse_start();
        chk("ss_period_e0", 64'(period), 1);
        chk("ss_busy_e0", 64'(busy), 1);
        tick(9);
        chk("ss_period_e9", 64'(period), 1);
        tick(1);
        chk("ss_period_e10", 64'(period), 0);
        tick(2);
        chk("ss_valid_e12", 64'(result_valid), 0);
        tick(1);
        chk("ss_valid_e13", 64'(result_valid), 1);
        chk("ss_data_e13", 64'(result_data), 1234);
        chk("ss_model_data", 64'(m_data), 1234);
        tick(2);
        chk("ss_busy_e15", 64'(busy), 1);
        tick(1);
        chk("ss_busy_e16", 64'(busy), 0);
        chk("ss_model_busy", 64'(m_busy), 0);
        result_ready = 1'b1;
        tick(1);
        chk("ss_consumed", 64'(result_valid), 0);

        // Continuous with ready held high
        cont = 1'b1;
        pulse_start();
        nr = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (period && !prev && nr < 3) begin rise[nr] = i; nr++; end
            prev = period;
            tick(1);
        end
        chk("cont_nrise", 64'(nr), 3);
        chk("cont_gap01", 64'(rise[1] - rise[0]), 16);
        chk("cont_gap12", 64'(rise[2] - rise[1]), 16);
        chk("cont_overrun", 64'(overrun), 0);
        cont = 1'b0;
        tick(20);
        chk("cont_idle", 64'(busy), 0);

        // Overrun
        result_ready = 1'b0; cont = 1'b1; counter_in = 40'd5;
        pulse_start();
        tick(13);
        chk("ov_data1", 64'(result_data), 5);
        chk("ov_ovr1", 64'(overrun), 0);
        counter_in = 40'd7;
        tick(16);
        chk("ov_data2", 64'(result_data), 7);
        chk("ov_valid2", 64'(result_valid), 1);
        chk("ov_ovr2", 64'(overrun), 1);
        chk("ov_model_ovr", 64'(m_ovr), 1);
        pulse_start();
        chk("ov_busy_start", 64'(overrun), 1);
        cont = 1'b0;
        tick(40);
        chk("ov_idle", 64'(busy), 0);
        result_ready = 1'b1; tick(1); result_ready = 1'b0;
        pulse_start();
        chk("ov_cleared", 64'(overrun), 0);
        tick(20);
        result_ready = 1'b1; tick(1); result_ready = 1'b0;

        // Reset in the middle of a gate
        pulse_start();
        tick(4);
        chk("mr_period_pre", 64'(period), 1);
        rst_n = 1'b0;
        tick(1);
        chk("mr_period", 64'(period), 0);
        chk("mr_busy", 64'(busy), 0);
        rst_n = 1'b1;
        tick(1);
        pulse_start();
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (period) hi++;
            tick(1);
        end
        chk("mr_gate_len", 64'(hi), G);
        tick(5);

        // Capture coinciding with valid&ready
        counter_in = 40'd11;
        pulse_start();
        tick(16);
        chk("sim_valid_pre", 64'(result_valid), 1);
        chk("sim_data_pre", 64'(result_data), 11);
        counter_in = 40'd22;
        pulse_start();
        tick(12);
        result_ready = 1'b1;
        tick(1);
        chk("sim_valid", 64'(result_valid), 1);
        chk("sim_data", 64'(result_data), 22);
        chk("sim_overrun", 64'(overrun), 0);
        result_ready = 1'b0;
        tick(5);

        // Random traffic, checked every cycle by the model process
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) cont = $urandom_range(0, 1) != 0;
            result_ready = $urandom_range(0, 2) == 0;
            rst_n        = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 3) == 0) begin
                r = {$urandom, $urandom};
                counter_in = r[CW-1:0];
            end
            tick(1);
        end
        rst_n = 1'b1; start = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
